// File: rtl/rssb_pkg.sv
// rssb_pkg: shared types and constants for the RSSB core (datapath + control).
//   DEF_DATA_W / DEF_ADDR_W : default word and address widths
//   word_t / addr_t         : default-width word and address types
//   io_addr(aw)             : all-ones address for an aw-bit address space
//   IO_ADDR                 : memory-mapped output address (used when RSSB_IO_EN is defined)
package rssb_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;

    typedef logic [DEF_DATA_W-1:0] word_t;
    typedef logic [DEF_ADDR_W-1:0] addr_t;

    function automatic int unsigned io_addr(input int unsigned aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

    localparam addr_t IO_ADDR = addr_t'(io_addr(DEF_ADDR_W));

endpackage

// File: rtl/rssb_mem.sv
// rssb_mem: unified RSSB word memory, 2**ADDR_W words, never reset.
//   clk                                  : write clock (rising edge)
//   i_prog_we/i_prog_addr/i_prog_wdata   : program-load write port (wins over datapath)
//   i_dp_we/i_dp_addr/i_dp_wdata         : datapath store port
//   i_rd_a_addr -> o_rd_a                : async read, operand-address field only
//   i_rd_b_addr -> o_rd_b                : async read, full data word
module rssb_mem
    import rssb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              i_prog_we,
    input  logic [ADDR_W-1:0] i_prog_addr,
    input  logic [DATA_W-1:0] i_prog_wdata,
    input  logic              i_dp_we,
    input  logic [ADDR_W-1:0] i_dp_addr,
    input  logic [DATA_W-1:0] i_dp_wdata,
    input  logic [ADDR_W-1:0] i_rd_a_addr,
    output logic [ADDR_W-1:0] o_rd_a,
    input  logic [ADDR_W-1:0] i_rd_b_addr,
    output logic [DATA_W-1:0] o_rd_b
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    // Loader owns the write port whenever it strobes; a colliding store is lost.
    always_comb begin
        w_we    = i_prog_we | i_dp_we;
        w_waddr = i_dp_addr;
        w_wdata = i_dp_wdata;
        if (i_prog_we) begin
            w_waddr = i_prog_addr;
            w_wdata = i_prog_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    // The instruction read only ever needs the address field of the word.
    assign o_rd_a = r_mem[i_rd_a_addr][ADDR_W-1:0];
    assign o_rd_b = r_mem[i_rd_b_addr];

endmodule

// File: rtl/rssb_datapath.sv
// rssb_datapath: PC / OP1 / ACC / neg registers plus word memory for the RSSB core.
//   clk, rst                      : clock, async active-high reset (memory survives reset)
//   write_op1                     : OP1 <= mem[PC] (address field)
//   write_acc                     : ACC <= mem[OP1] - ACC, neg <= sign of result
//   write_mem                     : mem[OP1] <= ACC
//   sel_pc, write_pc              : PC <= sel_pc ? PC+1 : PC when write_pc
//   neg                           : registered borrow flag
//   prog_we/prog_addr/prog_wdata  : program-load port, priority over write_mem
//   dbg_pc, dbg_acc               : register taps
// Optional (macro RSSB_IO_EN): io_out/io_valid, a store to the all-ones address
// also latches ACC into io_out and pulses io_valid for one cycle.
module rssb_datapath
    import rssb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_op1,
    input  logic              write_acc,
    input  logic              write_mem,
    input  logic              sel_pc,
    input  logic              write_pc,
    output logic              neg,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_wdata,
    output logic [ADDR_W-1:0] dbg_pc,
    output logic [DATA_W-1:0] dbg_acc
`ifdef RSSB_IO_EN
    ,
    output logic [DATA_W-1:0] io_out,
    output logic              io_valid
`endif
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_op1;
    logic [DATA_W-1:0] r_acc;
    logic              r_neg;

    logic [ADDR_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [DATA_W-1:0] w_diff;

    rssb_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
        .clk          (clk),
        .i_prog_we    (prog_we),
        .i_prog_addr  (prog_addr),
        .i_prog_wdata (prog_wdata),
        .i_dp_we      (write_mem),
        .i_dp_addr    (r_op1),
        .i_dp_wdata   (r_acc),
        .i_rd_a_addr  (r_pc),
        .o_rd_a       (w_rd_a),
        .i_rd_b_addr  (r_op1),
        .o_rd_b       (w_rd_b)
    );

    // Modulo-2**DATA_W subtract; the MSB doubles as the borrow/sign flag.
    assign w_diff = w_rd_b - r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc  <= '0;
            r_op1 <= '0;
            r_acc <= '0;
            r_neg <= 1'b0;
        end else begin
            if (write_op1) r_op1 <= w_rd_a;
            if (write_acc) begin
                r_acc <= w_diff;
                r_neg <= w_diff[DATA_W-1];
            end
            if (write_pc && sel_pc) r_pc <= r_pc + 1'b1;
        end
    end

`ifdef RSSB_IO_EN
    localparam logic [ADDR_W-1:0] IO_A = ADDR_W'(io_addr(ADDR_W));

    logic [DATA_W-1:0] r_io_out;
    logic              r_io_valid;

    // The store still lands in memory; this only mirrors it onto the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_io_out   <= '0;
            r_io_valid <= 1'b0;
        end else begin
            r_io_valid <= write_mem && (r_op1 == IO_A);
            if (write_mem && (r_op1 == IO_A)) r_io_out <= r_acc;
        end
    end

    assign io_out   = r_io_out;
    assign io_valid = r_io_valid;
`endif

    assign neg     = r_neg;
    assign dbg_pc  = r_pc;
    assign dbg_acc = r_acc;

endmodule
